// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer slice.
// Holds the FSM state encoding and the default counter and prescaler widths
// so the top level and the prescaler agree on them.
package timer_pkg;

  localparam int TIMER_WIDTH_DEFAULT   = 4;
  localparam int TIMER_PRESC_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } timer_state_e;

endpackage

// File: rtl/clk_prescaler.sv
// Programmable prescaler: produces a one-cycle tick every div+1 enabled cycles.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   en    - count enable; the count holds while low
//   clr   - synchronous clear back to 0, takes priority over en
//   div   - divisor; tick when the count equals div, then wrap to 0
//   tick  - combinational strobe, high when enabled and count == div
module clk_prescaler
  import timer_pkg::*;
#(
  parameter int W = TIMER_PRESC_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] div,
  output logic         tick
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    tick    = en && (count_q == div);
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = tick ? '0 : count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Countdown timer with prescaler, one-shot or periodic operation.
// Ports:
//   clk, rst_n  - rising-edge clock, asynchronous active-low reset
//   load_val    - countdown start value, captured on start
//   presc_div   - prescaler divisor (tick every presc_div+1 cycles), captured on start
//   start, stop - level controls sampled every cycle; stop beats start
//   auto_reload - 1 = periodic, 0 = one-shot; sampled at each terminal tick
//   cnt         - registered current count
//   busy, done  - state == RUN, state == DONE
//   tc_pulse    - registered one-cycle terminal-count strobe
module countdown_timer
  import timer_pkg::*;
#(
  parameter int WIDTH   = TIMER_WIDTH_DEFAULT,
  parameter int PRESC_W = TIMER_PRESC_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   load_val,
  input  logic [PRESC_W-1:0] presc_div,
  input  logic               start,
  input  logic               stop,
  input  logic               auto_reload,
  output logic [WIDTH-1:0]   cnt,
  output logic               busy,
  output logic               done,
  output logic               tc_pulse
);

  timer_state_e       state_q, state_d;
  logic [WIDTH-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   reload_r_q, reload_r_d;
  logic [PRESC_W-1:0] div_r_q, div_r_d;
  logic               tc_pulse_q, tc_pulse_d;

  logic presc_en;
  logic presc_clr;
  logic tick;

  assign presc_en = (state_q == ST_RUN);

  clk_prescaler #(
    .W(PRESC_W)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (presc_en),
    .clr  (presc_clr),
    .div  (div_r_q),
    .tick (tick)
  );

  // Start (or restart) is checked before the tick so a start coinciding with
  // a terminal tick reloads from load_val and suppresses tc_pulse; stop is
  // checked before both.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    reload_r_d = reload_r_q;
    div_r_d    = div_r_q;
    tc_pulse_d = 1'b0;
    presc_clr  = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start && !stop) begin
          state_d    = ST_RUN;
          cnt_d      = load_val;
          reload_r_d = load_val;
          div_r_d    = presc_div;
          presc_clr  = 1'b1;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (start) begin
          cnt_d      = load_val;
          reload_r_d = load_val;
          div_r_d    = presc_div;
          presc_clr  = 1'b1;
        end else if (tick) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - WIDTH'(1);
          end else begin
            tc_pulse_d = 1'b1;
            if (auto_reload) begin
              cnt_d = reload_r_q;
            end else begin
              state_d = ST_DONE;
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      reload_r_q <= '0;
      div_r_q    <= '0;
      tc_pulse_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      reload_r_q <= reload_r_d;
      div_r_q    <= div_r_d;
      tc_pulse_q <= tc_pulse_d;
    end
  end

  assign cnt      = cnt_q;
  assign busy     = (state_q == ST_RUN);
  assign done     = (state_q == ST_DONE);
  assign tc_pulse = tc_pulse_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios plus a random
// run, all compared against a behavioural model that derives the count from
// elapsed cycles since the last (re)load.
module tb_countdown_timer;

  localparam int WIDTH   = 4;
  localparam int PRESC_W = 8;

  localparam int MODE_IDLE = 0;
  localparam int MODE_RUN  = 1;
  localparam int MODE_DONE = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [WIDTH-1:0]   load_val = '0;
  logic [PRESC_W-1:0] presc_div = '0;
  logic               start = 1'b0;
  logic               stop = 1'b0;
  logic               auto_reload = 1'b0;
  logic [WIDTH-1:0]   cnt;
  logic               busy;
  logic               done;
  logic               tc_pulse;

  int tests_run = 0;
  int tests_failed = 0;

  // Model state: mode, expected count, captured reload/divisor and the number
  // of RUN cycles since the last load or reload.
  int m_mode;
  int m_cnt;
  int m_reload;
  int m_div;
  int m_phase;
  bit m_tc;

  countdown_timer #(
    .WIDTH  (WIDTH),
    .PRESC_W(PRESC_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_val   (load_val),
    .presc_div  (presc_div),
    .start      (start),
    .stop       (stop),
    .auto_reload(auto_reload),
    .cnt        (cnt),
    .busy       (busy),
    .done       (done),
    .tc_pulse   (tc_pulse)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    m_mode   = MODE_IDLE;
    m_cnt    = 0;
    m_reload = 0;
    m_div    = 0;
    m_phase  = 0;
    m_tc     = 1'b0;
  endtask

  task automatic modelLoad();
    m_mode   = MODE_RUN;
    m_reload = int'(load_val);
    m_div    = int'(presc_div);
    m_cnt    = m_reload;
    m_phase  = 0;
  endtask

  // One clock edge of behaviour. In RUN the count is the reload value minus
  // the number of whole prescaler periods elapsed; the terminal event falls
  // exactly (reload+1)*(div+1) cycles after a load.
  task automatic modelStep(input bit st, input bit sp);
    int period;
    m_tc = 1'b0;
    if (m_mode == MODE_RUN) begin
      if (sp) begin
        m_mode = MODE_IDLE;
      end else if (st) begin
        modelLoad();
      end else begin
        m_phase++;
        period = (m_reload + 1) * (m_div + 1);
        if (m_phase == period) begin
          m_tc = 1'b1;
          if (auto_reload) begin
            m_phase = 0;
            m_cnt   = m_reload;
          end else begin
            m_mode = MODE_DONE;
            m_cnt  = 0;
          end
        end else begin
          m_cnt = m_reload - m_phase / (m_div + 1);
        end
      end
    end else if (st && !sp) begin
      modelLoad();
    end
  endtask

  task automatic checkModel();
    checkOutput("cnt", cnt, m_cnt);
    checkOutput("busy", busy, m_mode == MODE_RUN);
    checkOutput("done", done, m_mode == MODE_DONE);
    checkOutput("tc_pulse", tc_pulse, m_tc);
  endtask

  // Drive start/stop for one edge, advance the model, check 1 time unit later.
  task automatic applyStimulus(input bit st, input bit sp);
    start = st;
    stop  = sp;
    @(posedge clk);
    modelStep(st, sp);
    #1;
    checkModel();
    start = 1'b0;
    stop  = 1'b0;
  endtask

  // Idle cycles until tc_pulse is seen; n is the number of edges taken.
  task automatic waitTc(input int limit, output int n);
    bit found;
    found = 1'b0;
    n = 0;
    while (!found && n < limit) begin
      applyStimulus(1'b0, 1'b0);
      n++;
      if (tc_pulse === 1'b1) found = 1'b1;
    end
    if (!found) checkOutput("tc_timeout", 0, 1);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    modelReset();

    // Reset state, then release between edges so the next edge sees start.
    repeat (3) @(posedge clk);
    #1;
    checkModel();
    @(negedge clk);
    rst_n = 1'b1;

    // One-shot countdown 3,2,1,0 with tc_pulse 4 cycles after start.
    load_val = 4'd3; presc_div = 8'd0; auto_reload = 1'b0;
    applyStimulus(1'b1, 1'b0);
    checkOutput("oneshot_load", cnt, 3);
    waitTc(20, n);
    checkOutput("oneshot_period", n, 4);
    checkOutput("oneshot_done", done, 1);
    checkOutput("oneshot_busy", busy, 0);
    repeat (5) applyStimulus(1'b0, 1'b0);

    // Periodic with prescaler; load_val changes mid-run must be ignored.
    load_val = 4'd2; presc_div = 8'd4; auto_reload = 1'b1;
    applyStimulus(1'b1, 1'b0);
    load_val = 4'd7;
    for (int p = 0; p < 5; p++) begin
      waitTc(40, n);
      checkOutput("periodic_period", n, 15);
      checkOutput("periodic_reload", cnt, 2);
    end

    // Stop and start together: stop wins, count held; stop in IDLE is inert.
    load_val = 4'd9; presc_div = 8'd0; auto_reload = 1'b0;
    applyStimulus(1'b1, 1'b0);
    repeat (4) applyStimulus(1'b0, 1'b0);
    checkOutput("prio_cnt_before", cnt, 5);
    applyStimulus(1'b1, 1'b1);
    checkOutput("prio_busy", busy, 0);
    checkOutput("prio_cnt", cnt, 5);
    checkOutput("prio_tc", tc_pulse, 0);
    repeat (3) applyStimulus(1'b0, 1'b1);
    checkOutput("idle_stop_cnt", cnt, 5);
    load_val = 4'd6;
    applyStimulus(1'b1, 1'b0);
    checkOutput("prio_reload", cnt, 6);

    // Restart at cnt=7 reloads 15; first tc_pulse 16 cycles later.
    load_val = 4'd15;
    applyStimulus(1'b1, 1'b0);
    repeat (8) applyStimulus(1'b0, 1'b0);
    checkOutput("restart_cnt_before", cnt, 7);
    applyStimulus(1'b1, 1'b0);
    checkOutput("restart_cnt", cnt, 15);
    waitTc(40, n);
    checkOutput("restart_period", n, 16);

    // Stop on the terminal tick: IDLE, no pulse.
    load_val = 4'd1;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("stop_tc_pulse", tc_pulse, 0);
    checkOutput("stop_tc_done", done, 0);

    // Start on the terminal tick: reload from load_val, no pulse.
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    load_val = 4'd4;
    applyStimulus(1'b1, 1'b0);
    checkOutput("start_tc_pulse", tc_pulse, 0);
    checkOutput("start_tc_cnt", cnt, 4);

    // Asynchronous reset between edges at cnt=9.
    load_val = 4'd12;
    applyStimulus(1'b1, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b0);
    checkOutput("rst_cnt_before", cnt, 9);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_cnt", cnt, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_tc", tc_pulse, 0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    load_val = 4'd0; presc_div = 8'd0;
    applyStimulus(1'b1, 1'b0);
    waitTc(5, n);
    checkOutput("rst_restart_period", n, 1);

    // Maximum divisor; changing presc_div mid-run must not alter the period.
    load_val = 4'd0; presc_div = 8'd255; auto_reload = 1'b0;
    applyStimulus(1'b1, 1'b0);
    repeat (10) applyStimulus(1'b0, 1'b0);
    presc_div = 8'd1;
    waitTc(300, n);
    checkOutput("presc255_period", n + 10, 256);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      auto_reload = ($urandom_range(0, 3) != 0);
      load_val    = WIDTH'($urandom_range(0, 15));
      presc_div   = PRESC_W'($urandom_range(0, 3));
      applyStimulus($urandom_range(0, 39) == 0, $urandom_range(0, 59) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
